// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package sevenseg_pkg;

  // Segment patterns for hex digits 0..F, stored active-low, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // All segments dark, in the active-low storage convention
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Convert an active-low pattern to the board's pin polarity
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_al, input logic active_low);
    seg_polarity = active_low ? seg_al : ~seg_al;
  endfunction

endpackage

// File: rtl/sevenseg_hex7seg.sv
// Combinational hex nibble to segment pattern lookup (active-low patterns).
module hex7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex display driver: shadow register, slot FSM with
// anti-ghosting blank phase, leading-zero suppression, registered pin outputs.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZ_SUPPRESS    = 0,
  localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  // With no blank phase a slot begins directly in SHOW
  localparam scan_state_e SLOT_START = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
  localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_AL  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_INACT = seg_polarity(SEG_OFF, SEG_AL);
  localparam logic              DP_INACT  = SEG_AL;
  localparam logic [DIGITS-1:0] AN_INACT  = {DIGITS{AN_AL}};

  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0]  shadow_val_q;
  logic [DIGITS-1:0]    shadow_dp_q;
  logic [3:0]           dig_nib_q, dig_nib_d;
  logic                 dig_dp_q, dig_dp_d;
  logic                 dig_sup_q, dig_sup_d;
  logic                 slot_start_s;
  logic [DIGITS-1:0]    zero_from_s;
  logic [DIGITS-1:0]    onehot_s;
  logic [6:0]           hex_seg_s;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [IDX_W-1:0]     idx_out_q, idx_out_d;

  // Capture the host value whenever load_i is high, regardless of scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
    end else if (load_i) begin
      shadow_val_q <= value_i;
      shadow_dp_q  <= dp_i;
    end else begin
      shadow_val_q <= shadow_val_q;
      shadow_dp_q  <= shadow_dp_q;
    end
  end

  // Slot sequencing: blank phase, show phase, advance digit; en_i low forces IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = SLOT_START;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            state_d = SLOT_START;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            state_d = ST_SHOW;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // FSM state, slot counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // zero_from_s[i]: shadow nibbles i..DIGITS-1 are all zero
  always_comb begin
    zero_from_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_from_s[i] = ((shadow_val_q >> (4 * i)) == '0);
    end
  end

  // Sample the digit for the upcoming slot so a mid-slot load cannot disturb it
  always_comb begin
    slot_start_s = (state_d != ST_IDLE) && (cnt_d == '0);
    dig_nib_d    = dig_nib_q;
    dig_dp_d     = dig_dp_q;
    dig_sup_d    = dig_sup_q;
    if (slot_start_s) begin
      dig_nib_d = shadow_val_q[{idx_d, 2'b00} +: 4];
      dig_dp_d  = shadow_dp_q[idx_d];
      dig_sup_d = (LZ_SUPPRESS != 0) && (idx_d != '0) && zero_from_s[idx_d];
    end else begin
      dig_nib_d = dig_nib_q;
    end
  end

  // Digit register D, held for the whole slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_nib_q <= 4'h0;
      dig_dp_q  <= 1'b0;
      dig_sup_q <= 1'b0;
    end else begin
      dig_nib_q <= dig_nib_d;
      dig_dp_q  <= dig_dp_d;
      dig_sup_q <= dig_sup_d;
    end
  end

  hex7seg u_hex7seg (
    .nib_i (dig_nib_q),
    .seg_o (hex_seg_s)
  );

  // Pin values for the next cycle; dark whenever disabled, idle or blanking
  always_comb begin
    seg_d     = SEG_INACT;
    dp_d      = DP_INACT;
    an_d      = AN_INACT;
    idx_out_d = '0;
    onehot_s  = '0;
    onehot_s[idx_q] = 1'b1;
    if (en_i && (state_q != ST_IDLE)) begin
      idx_out_d = idx_q;
      if (state_q == ST_SHOW) begin
        an_d = AN_AL ? ~onehot_s : onehot_s;
        if (dig_sup_q) begin
          seg_d = SEG_INACT;
          dp_d  = DP_INACT;
        end else begin
          seg_d = seg_polarity(hex_seg_s, SEG_AL);
          dp_d  = dig_dp_q ? ~DP_INACT : DP_INACT;
        end
      end else begin
        an_d = AN_INACT;
      end
    end else begin
      idx_out_d = '0;
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= SEG_INACT;
      dp_q      <= DP_INACT;
      an_q      <= AN_INACT;
      idx_out_q <= '0;
    end else begin
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      idx_out_q <= idx_out_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;
  assign idx_o = idx_out_q;

endmodule
